// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit and the hazard logic.
// Optional build macro: MD_UNIT_MADD_EN adds the MADD/MADDU/MSUB/MSUBU op codes.
package md_pkg;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MFHI  = 4'd5,
        MD_MFLO  = 4'd6,
        MD_MTHI  = 4'd7,
        MD_MTLO  = 4'd8
`ifdef MD_UNIT_MADD_EN
        ,
        MD_MADD  = 4'd9,
        MD_MADDU = 4'd10,
        MD_MSUB  = 4'd11,
        MD_MSUBU = 4'd12
`endif
    } md_op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } md_state_e;

    // True for ops that occupy the unit for multiple cycles.
    function automatic logic is_md_compute(input logic [3:0] op);
        case (op)
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: return 1'b1;
`ifdef MD_UNIT_MADD_EN
            MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

    // True for ops that take the divide latency.
    function automatic logic is_md_div(input logic [3:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/md_calc.sv
// Combinational datapath for the multiply/divide unit: produces the new
// {HI,LO} from the latched operands, the latched op and the current {HI,LO}.
// Optional build macro: MD_UNIT_MADD_EN adds multiply-accumulate/subtract.
module md_calc
    import md_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    output logic [63:0] result
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        sdiv;
    logic [31:0] dvd;
    logic [31:0] dvs;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quot;
    logic [31:0] rem;

    assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    assign prod_u = {32'd0, a} * {32'd0, b};

    // Signed divide works on magnitudes so INT_MIN / -1 wraps back to INT_MIN.
    always_comb begin
        sdiv  = (op == MD_DIV);
        dvd   = (sdiv && a[31]) ? (~a + 32'd1) : a;
        dvs   = (sdiv && b[31]) ? (~b + 32'd1) : b;
        q_mag = '0;
        r_mag = '0;
        if (dvs != '0) begin
            q_mag = dvd / dvs;
            r_mag = dvd % dvs;
        end
        quot = (sdiv && (a[31] ^ b[31])) ? (~q_mag + 32'd1) : q_mag;
        rem  = (sdiv && a[31]) ? (~r_mag + 32'd1) : r_mag;
    end

    // Result select; divide by zero and unknown ops keep {HI,LO} as they are.
    always_comb begin
        result = {hi, lo};
        case (op)
            MD_MULT:  result = prod_s;
            MD_MULTU: result = prod_u;
            MD_DIV, MD_DIVU: begin
                if (b != '0) begin
                    result = {rem, quot};
                end
            end
`ifdef MD_UNIT_MADD_EN
            MD_MADD:  result = {hi, lo} + prod_s;
            MD_MADDU: result = {hi, lo} + prod_u;
            MD_MSUB:  result = {hi, lo} - prod_s;
            MD_MSUBU: result = {hi, lo} - prod_u;
`endif
            default:  result = {hi, lo};
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// E-stage multiply/divide unit: fixed-latency mult/div, HI/LO registers,
// mthi/mtlo writes and mfhi/mflo read mux. busy feeds the hazard logic.
// Optional build macro: MD_UNIT_MADD_EN enables MADD/MADDU/MSUB/MSUBU.
module md_unit
    import md_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [3:0]  md_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] rd_data
);

    md_state_e   state;
    logic [3:0]  cnt;
    logic [3:0]  lat;
    logic [3:0]  op_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [63:0] result;

    md_calc u_calc (
        .op     (op_q),
        .a      (a_q),
        .b      (b_q),
        .hi     (hi),
        .lo     (lo),
        .result (result)
    );

    // Latency for the op being issued.
    always_comb begin
        lat = is_md_div(md_op) ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
    end

    // FSM, countdown, operand latches and HI/LO architectural registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
            op_q  <= MD_NONE;
            a_q   <= '0;
            b_q   <= '0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && is_md_compute(md_op)) begin
                        op_q  <= md_op;
                        a_q   <= a;
                        b_q   <= b;
                        cnt   <= lat;
                        state <= S_RUN;
                        busy  <= 1'b1;
                    end else if (md_op == MD_MTHI) begin
                        hi <= a;
                    end else if (md_op == MD_MTLO) begin
                        lo <= a;
                    end
                end
                S_RUN: begin
                    if (cnt == 4'd1) begin
                        {hi, lo} <= result;
                        cnt      <= '0;
                        state    <= S_IDLE;
                        busy     <= 1'b0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign rd_data = (md_op == MD_MFHI) ? hi : lo;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: vector table plus scoreboard queue,
// with hand-written sequences for reset, restart, MT/MF and madd cases.
module tb_md_unit;
    import md_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [3:0]  md_op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] rd_data;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] pre_hi;
        logic [31:0] pre_lo;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int unsigned lat;
        string       name;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int unsigned lat;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[11];

    always #5 clk = ~clk;

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .md_op   (md_op),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .hi      (hi),
        .lo      (lo),
        .rd_data (rd_data)
    );

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int unsigned act, input int unsigned exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Single-cycle mthi/mtlo write.
    task automatic mt(input logic [3:0] op, input logic [31:0] v);
        @(negedge clk);
        md_op = op;
        a     = v;
        @(negedge clk);
        md_op = MD_NONE;
        a     = '0;
    endtask

    // Issue a compute op and push its expected outcome.
    task automatic issue(input logic [3:0] op, input logic [31:0] va, input logic [31:0] vb,
                         input logic [31:0] eh, input logic [31:0] el, input int unsigned n);
        @(negedge clk);
        md_op = op;
        a     = va;
        b     = vb;
        start = 1'b1;
        sb.push_back('{hi: eh, lo: el, lat: n});
        @(negedge clk);
        start = 1'b0;
        md_op = MD_NONE;
    endtask

    // Count busy cycles (bounded), then pop and compare the result.
    task automatic wait_done(input string name, input bit inject);
        int unsigned c = 0;
        exp_t e;
        while (busy === 1'b1 && c < 40) begin
            if (inject && c == 2) begin
                start = 1'b1;
                md_op = MD_DIVU;
                a     = 32'd100;
                b     = 32'd7;
            end else begin
                start = 1'b0;
                md_op = MD_NONE;
            end
            c++;
            @(negedge clk);
        end
        start = 1'b0;
        md_op = MD_NONE;
        e = sb.pop_front();
        check_int({name, "_latency"}, c, e.lat);
        check32({name, "_hi"}, hi, e.hi);
        check32({name, "_lo"}, lo, e.lo);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [3:0] madd_code;
        vecs[0]  = '{MD_MULT,  32'hFFFFFFFE, 32'd3,        0, 0, 32'hFFFFFFFF, 32'hFFFFFFFA, 5,  "mult_neg"};
        vecs[1]  = '{MD_MULTU, 32'hFFFFFFFE, 32'd3,        0, 0, 32'h00000002, 32'hFFFFFFFA, 5,  "multu"};
        vecs[2]  = '{MD_MULT,  32'h7FFFFFFF, 32'h7FFFFFFF, 0, 0, 32'h3FFFFFFF, 32'h00000001, 5,  "mult_max"};
        vecs[3]  = '{MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 32'hFFFFFFFE, 32'h00000001, 5,  "multu_max"};
        vecs[4]  = '{MD_DIV,   32'hFFFFFFF9, 32'd2,        0, 0, 32'hFFFFFFFF, 32'hFFFFFFFD, 10, "div_neg"};
        vecs[5]  = '{MD_DIVU,  32'd7,        32'd2,        0, 0, 32'h00000001, 32'h00000003, 10, "divu"};
        vecs[6]  = '{MD_DIV,   32'd7,        32'hFFFFFFFE, 0, 0, 32'h00000001, 32'hFFFFFFFD, 10, "div_negdivisor"};
        vecs[7]  = '{MD_DIV,   32'hFFFFFFF8, 32'hFFFFFFFD, 0, 0, 32'hFFFFFFFE, 32'h00000002, 10, "div_bothneg"};
        vecs[8]  = '{MD_DIVU,  32'd5,        32'd0, 32'h11, 32'h22, 32'h00000011, 32'h00000022, 10, "divu_by_zero"};
        vecs[9]  = '{MD_DIV,   32'hFFFFFFF9, 32'd0, 32'hAA, 32'hBB, 32'h000000AA, 32'h000000BB, 10, "div_by_zero"};
        vecs[10] = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 7, 9, 32'h00000000, 32'h80000000, 10, "div_overflow"};

        rst_n = 1'b0;
        start = 1'b0;
        md_op = MD_NONE;
        a     = '0;
        b     = '0;
        repeat (2) @(negedge clk);
        check32("reset_busy", {31'd0, busy}, 32'd0);
        check32("reset_hi", hi, 32'd0);
        check32("reset_lo", lo, 32'd0);
        rst_n = 1'b1;

        // Table-driven arithmetic vectors.
        for (int i = 0; i < 11; i++) begin
            mt(MD_MTHI, vecs[i].pre_hi);
            mt(MD_MTLO, vecs[i].pre_lo);
            issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_hi, vecs[i].exp_lo, vecs[i].lat);
            wait_done(vecs[i].name, 1'b0);
        end

        // MT/MF path: write then read on the following cycle, busy never set.
        mt(MD_MTLO, 32'hDEADBEEF);
        check32("mt_busy", {31'd0, busy}, 32'd0);
        md_op = MD_MFLO;
        #1;
        check32("mflo_rd", rd_data, 32'hDEADBEEF);
        mt(MD_MTHI, 32'h12345678);
        check32("mthi_busy", {31'd0, busy}, 32'd0);
        md_op = MD_MFHI;
        #1;
        check32("mfhi_rd", rd_data, 32'h12345678);
        check32("mthi_keeps_lo", lo, 32'hDEADBEEF);
        md_op = MD_NONE;

        // start during RUN must not disturb the mult in flight.
        mt(MD_MTHI, 32'd0);
        mt(MD_MTLO, 32'd0);
        issue(MD_MULT, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA, 5);
        wait_done("restart", 1'b1);
        repeat (2) @(negedge clk);
        check32("restart_idle", {31'd0, busy}, 32'd0);

        // start with a non-compute op is a no-op.
        @(negedge clk);
        md_op = MD_MFLO;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        md_op = MD_NONE;
        check32("noop_busy", {31'd0, busy}, 32'd0);
        check32("noop_lo", lo, 32'hFFFFFFFA);

        // Multiply-accumulate family.
        mt(MD_MTHI, 32'd0);
        mt(MD_MTLO, 32'd5);
`ifdef MD_UNIT_MADD_EN
        issue(MD_MADDU, 32'd3, 32'd4, 32'd0, 32'd17, 5);
        wait_done("maddu", 1'b0);
        mt(MD_MTLO, 32'd5);
        issue(MD_MSUB, 32'd2, 32'd4, 32'hFFFFFFFF, 32'hFFFFFFFD, 5);
        wait_done("msub", 1'b0);
`else
        madd_code = 4'd10;
        @(negedge clk);
        md_op = madd_code;
        a     = 32'd3;
        b     = 32'd4;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        md_op = MD_NONE;
        check32("madd_off_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        check32("madd_off_lo", lo, 32'd5);
        check32("madd_off_hi", hi, 32'd0);
`endif

        // Asynchronous reset in the middle of a divide.
        mt(MD_MTHI, 32'h55);
        mt(MD_MTLO, 32'h66);
        @(negedge clk);
        md_op = MD_DIV;
        a     = 32'd100;
        b     = 32'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        md_op = MD_NONE;
        check32("rst_run_busy", {31'd0, busy}, 32'd1);
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check32("rst_async_busy", {31'd0, busy}, 32'd0);
        check32("rst_async_hi", hi, 32'd0);
        check32("rst_async_lo", lo, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check32("rst_after_busy", {31'd0, busy}, 32'd0);
        check32("rst_after_lo", lo, 32'd0);

        // Unit still works after the abort.
        issue(MD_DIVU, 32'd7, 32'd2, 32'd1, 32'd3, 10);
        wait_done("post_reset_divu", 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
